// File: rtl/noc_board_pkg.sv
// Shared constants, entry layout and 7-segment glyph helper for the NoC demo board.
package noc_board_pkg;

    localparam int NR      = 9;
    localparam int PW      = 9;
    localparam int PAY_W   = 8;
    localparam int IDX_W   = 4;
    localparam int ENTRY_W = IDX_W + PAY_W;

    localparam logic [6:0] SEG_DASH = ~7'b0000001;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [PAY_W-1:0] data;
    } entry_t;

    // Active-low abcdefg glyph for one hex digit.
    function automatic logic [6:0] seg7_hex(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1111110;
            4'h1:    seg = 7'b0110000;
            4'h2:    seg = 7'b1101101;
            4'h3:    seg = 7'b1111001;
            4'h4:    seg = 7'b0110011;
            4'h5:    seg = 7'b1011011;
            4'h6:    seg = 7'b1011111;
            4'h7:    seg = 7'b1110000;
            4'h8:    seg = 7'b1111111;
            4'h9:    seg = 7'b1111011;
            4'hA:    seg = 7'b1110111;
            4'hB:    seg = 7'b0011111;
            4'hC:    seg = 7'b1001110;
            4'hD:    seg = 7'b0111101;
            4'hE:    seg = 7'b1001111;
            4'hF:    seg = 7'b1000111;
            default: seg = 7'b0000001;
        endcase
        return ~seg;
    endfunction

endpackage

// File: rtl/pkt_fifo.sv
// Synchronous FIFO for captured packets; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module pkt_fifo
    import noc_board_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = ENTRY_W,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  head,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push_s, do_pop_s;

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head      = mem_q[rd_ptr_q];
    assign do_pop_s  = pop & ~empty & ~clear;
    assign do_push_s = push & (~full | do_pop_s) & ~clear;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (do_push_s && (wr_ptr_q == AW'(i))) begin
                mem_d[i] = wdata;
            end else begin
                mem_d[i] = mem_q[i];
            end
        end
        wr_ptr_d = clear ? '0 : (do_push_s ? wr_ptr_q + AW'(1) : wr_ptr_q);
        rd_ptr_d = clear ? '0 : (do_pop_s  ? rd_ptr_q + AW'(1) : rd_ptr_q);
        case ({clear, do_push_s, do_pop_s})
            3'b010:  count_d = count_q + (AW+1)'(1);
            3'b001:  count_d = count_q - (AW+1)'(1);
            3'b100,
            3'b101,
            3'b110,
            3'b111:  count_d = '0;
            default: count_d = count_q;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/collect_data_9.sv
// Packet sink for the 9-router NoC board: detects arrivals, queues them with
// their router number and shows the queue head on 7-segment displays.
module collect_data_9
    import noc_board_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [PW-1:0] in_router1,
    input  logic [PW-1:0] in_router2,
    input  logic [PW-1:0] in_router3,
    input  logic [PW-1:0] in_router4,
    input  logic [PW-1:0] in_router5,
    input  logic [PW-1:0] in_router6,
    input  logic [PW-1:0] in_router7,
    input  logic [PW-1:0] in_router8,
    input  logic [PW-1:0] in_router9,
    input  logic          sw_clear,
    input  logic          key_next,
    output logic [6:0]    hex_router,
    output logic [6:0]    hex_data_hi,
    output logic [6:0]    hex_data_lo,
    output logic [6:0]    hex_count,
    output logic          led_overrun,
    output logic [7:0]    pkt_total
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [PW-1:0]    in_s [NR];
    logic [NR-1:0]    valid_s, arrive_s, clr_oh_s;
    logic [NR-1:0]    prev_v_q, prev_v_d, pend_q, pend_d;
    logic [PAY_W-1:0] pend_data_q [NR];
    logic [PAY_W-1:0] pend_data_d [NR];
    logic             key_prev_q, key_prev_d;
    logic             overrun_q, overrun_d;
    logic [7:0]       pkt_total_q, pkt_total_d;
    logic [6:0]       hex_router_q, hex_router_d, hex_hi_q, hex_hi_d;
    logic [6:0]       hex_lo_q, hex_lo_d, hex_count_q, hex_count_d;
    logic             key_edge_s, pop_s, push_s, any_pend_s;
    logic             fifo_full_s, fifo_empty_s;
    logic [CW-1:0]    fifo_count_s;
    logic [IDX_W-1:0] sel_s;
    entry_t           push_entry_s, head_s;

    assign in_s[0] = in_router1;
    assign in_s[1] = in_router2;
    assign in_s[2] = in_router3;
    assign in_s[3] = in_router4;
    assign in_s[4] = in_router5;
    assign in_s[5] = in_router6;
    assign in_s[6] = in_router7;
    assign in_s[7] = in_router8;
    assign in_s[8] = in_router9;

    assign arrive_s   = valid_s & ~prev_v_q & {NR{~sw_clear}};
    assign key_edge_s = key_next & ~key_prev_q;
    assign pop_s      = key_edge_s & ~fifo_empty_s & ~sw_clear;
    assign any_pend_s = |pend_q;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_s     = any_pend_s & ~sw_clear & (~fifo_full_s | pop_s);
    assign clr_oh_s   = push_s ? (NR'(1) << sel_s) : '0;

    assign push_entry_s.idx  = sel_s + IDX_W'(1);
    assign push_entry_s.data = pend_data_q[sel_s];

    // Valid bits and lowest-index pending router.
    always_comb begin
        valid_s = '0;
        sel_s   = '0;
        for (int i = 0; i < NR; i++) begin
            valid_s[i] = in_s[i][PW-1];
        end
        for (int i = NR - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                sel_s = IDX_W'(i);
            end else begin
                sel_s = sel_s;
            end
        end
    end

    // Pending stage, overrun, counters and display next-state.
    always_comb begin
        overrun_d = overrun_q;
        for (int i = 0; i < NR; i++) begin
            pend_data_d[i] = pend_data_q[i];
            pend_d[i]      = pend_q[i];
            if (arrive_s[i]) begin
                pend_data_d[i] = in_s[i][PAY_W-1:0];
                pend_d[i]      = 1'b1;
                if (pend_q[i] && !clr_oh_s[i]) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_d;
                end
            end else if (clr_oh_s[i]) begin
                pend_d[i] = 1'b0;
            end else begin
                pend_d[i] = pend_q[i];
            end
        end
        if (sw_clear) begin
            pend_d    = '0;
            overrun_d = 1'b0;
        end else begin
            pend_d    = pend_d;
        end
        prev_v_d    = valid_s;
        key_prev_d  = key_next;
        pkt_total_d = pkt_total_q + (push_s ? 8'd1 : 8'd0);
        if (fifo_empty_s) begin
            hex_router_d = SEG_DASH;
            hex_hi_d     = SEG_DASH;
            hex_lo_d     = SEG_DASH;
        end else begin
            hex_router_d = seg7_hex(head_s.idx);
            hex_hi_d     = seg7_hex(head_s.data[7:4]);
            hex_lo_d     = seg7_hex(head_s.data[3:0]);
        end
        hex_count_d = seg7_hex(4'(fifo_count_s));
    end

    pkt_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (sw_clear),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (push_entry_s),
        .head  (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_v_q     <= '0;
            pend_q       <= '0;
            for (int i = 0; i < NR; i++) begin
                pend_data_q[i] <= '0;
            end
            key_prev_q   <= 1'b0;
            overrun_q    <= 1'b0;
            pkt_total_q  <= 8'd0;
            hex_router_q <= SEG_DASH;
            hex_hi_q     <= SEG_DASH;
            hex_lo_q     <= SEG_DASH;
            hex_count_q  <= seg7_hex(4'd0);
        end else begin
            prev_v_q     <= prev_v_d;
            pend_q       <= pend_d;
            for (int i = 0; i < NR; i++) begin
                pend_data_q[i] <= pend_data_d[i];
            end
            key_prev_q   <= key_prev_d;
            overrun_q    <= overrun_d;
            pkt_total_q  <= pkt_total_d;
            hex_router_q <= hex_router_d;
            hex_hi_q     <= hex_hi_d;
            hex_lo_q     <= hex_lo_d;
            hex_count_q  <= hex_count_d;
        end
    end

    assign hex_router  = hex_router_q;
    assign hex_data_hi = hex_hi_q;
    assign hex_data_lo = hex_lo_q;
    assign hex_count   = hex_count_q;
    assign led_overrun = overrun_q;
    assign pkt_total   = pkt_total_q;

endmodule

// File: tb/tb_collect_data_9.sv
// Self-checking bench for collect_data_9: directed scenarios plus random
// traffic, all checked against a queue-based packet model.
module tb_collect_data_9;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [8:0] rin [9];
    logic       sw_clear, key_next;
    logic [6:0] hex_router, hex_data_hi, hex_data_lo, hex_count;
    logic       led_overrun;
    logic [7:0] pkt_total;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [6:0] DASH = 7'b1111110;

    always #5 clk = ~clk;

    collect_data_9 dut (
        .clk(clk), .rst_n(rst_n),
        .in_router1(rin[0]), .in_router2(rin[1]), .in_router3(rin[2]),
        .in_router4(rin[3]), .in_router5(rin[4]), .in_router6(rin[5]),
        .in_router7(rin[6]), .in_router8(rin[7]), .in_router9(rin[8]),
        .sw_clear(sw_clear), .key_next(key_next),
        .hex_router(hex_router), .hex_data_hi(hex_data_hi), .hex_data_lo(hex_data_lo),
        .hex_count(hex_count), .led_overrun(led_overrun), .pkt_total(pkt_total)
    );

    // Reference model state
    bit          m_prev [9];
    bit          m_pend [9];
    logic [7:0]  m_pdata [9];
    logic [11:0] m_q [$];
    bit          m_ovr;
    logic [7:0]  m_total;
    bit          m_keyp;
    logic [6:0]  e_router, e_hi, e_lo, e_cnt;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;  default: return 7'b0111000;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 9; i++) begin
            m_prev[i] = 1'b0; m_pend[i] = 1'b0; m_pdata[i] = 8'h00;
        end
        m_q.delete();
        m_ovr = 1'b0; m_total = 8'd0; m_keyp = 1'b0;
        e_router = DASH; e_hi = DASH; e_lo = DASH; e_cnt = glyph(4'd0);
    endtask

    // One clock of packet behaviour; displays reflect the queue before this edge.
    task automatic model_step();
        bit key_edge;
        bit do_pop;
        int sel;
        e_cnt = glyph(4'(m_q.size()));
        if (m_q.size() == 0) begin
            e_router = DASH; e_hi = DASH; e_lo = DASH;
        end else begin
            e_router = glyph(m_q[0][11:8]);
            e_hi     = glyph(m_q[0][7:4]);
            e_lo     = glyph(m_q[0][3:0]);
        end
        key_edge = key_next && !m_keyp;
        m_keyp   = key_next;
        if (sw_clear) begin
            m_q.delete();
            for (int i = 0; i < 9; i++) m_pend[i] = 1'b0;
            m_ovr = 1'b0;
        end else begin
            do_pop = key_edge && (m_q.size() > 0);
            sel = -1;
            for (int i = 0; i < 9; i++) if (m_pend[i] && sel < 0) sel = i;
            if (do_pop) void'(m_q.pop_front());
            if (sel >= 0 && m_q.size() < 4) begin
                m_q.push_back({4'(sel + 1), m_pdata[sel]});
                m_pend[sel] = 1'b0;
                m_total = m_total + 8'd1;
            end
            for (int i = 0; i < 9; i++) begin
                if (rin[i][8] && !m_prev[i]) begin
                    if (m_pend[i]) m_ovr = 1'b1;
                    m_pend[i]  = 1'b1;
                    m_pdata[i] = rin[i][7:0];
                end
            end
        end
        for (int i = 0; i < 9; i++) m_prev[i] = rin[i][8];
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic press_key();
        key_next = 1'b1; tick();
        key_next = 1'b0; tick();
    endtask

    task automatic clear_all();
        for (int i = 0; i < 9; i++) rin[i] = 9'h000;
        key_next = 1'b0;
        sw_clear = 1'b1; tick();
        sw_clear = 1'b0; ticks(2);
    endtask

    task automatic test_reset();
        n_checks += 6;
        if (hex_router !== DASH) begin n_errors++; $display("FAIL reset_router got %b want %b", hex_router, DASH); end
        if (hex_data_hi !== DASH) begin n_errors++; $display("FAIL reset_hi got %b want %b", hex_data_hi, DASH); end
        if (hex_data_lo !== DASH) begin n_errors++; $display("FAIL reset_lo got %b want %b", hex_data_lo, DASH); end
        if (hex_count !== glyph(4'd0)) begin n_errors++; $display("FAIL reset_count got %b want %b", hex_count, glyph(4'd0)); end
        if (led_overrun !== 1'b0) begin n_errors++; $display("FAIL reset_ovr got %b want 0", led_overrun); end
        if (pkt_total !== 8'd0) begin n_errors++; $display("FAIL reset_total got %0d want 0", pkt_total); end
    endtask

    task automatic test_single();
        rin[2] = 9'h125;
        ticks(3);
        n_checks += 5;
        if (hex_router !== glyph(4'd3)) begin n_errors++; $display("FAIL single_router got %b want %b", hex_router, glyph(4'd3)); end
        if (hex_data_hi !== glyph(4'd2)) begin n_errors++; $display("FAIL single_hi got %b want %b", hex_data_hi, glyph(4'd2)); end
        if (hex_data_lo !== glyph(4'd5)) begin n_errors++; $display("FAIL single_lo got %b want %b", hex_data_lo, glyph(4'd5)); end
        if (hex_count !== glyph(4'd1)) begin n_errors++; $display("FAIL single_count got %b want %b", hex_count, glyph(4'd1)); end
        if (pkt_total !== 8'd1) begin n_errors++; $display("FAIL single_total got %0d want 1", pkt_total); end
        ticks(5);
        n_checks += 2;
        if (hex_count !== glyph(4'd1)) begin n_errors++; $display("FAIL single_held_count got %b want %b", hex_count, glyph(4'd1)); end
        if (pkt_total !== 8'd1) begin n_errors++; $display("FAIL single_held_total got %0d want 1", pkt_total); end
    endtask

    task automatic test_simultaneous();
        clear_all();
        rin[6] = 9'h111; rin[1] = 9'h122;
        ticks(4);
        n_checks += 3;
        if (hex_count !== glyph(4'd2)) begin n_errors++; $display("FAIL simul_count got %b want %b", hex_count, glyph(4'd2)); end
        if (hex_router !== glyph(4'd2)) begin n_errors++; $display("FAIL simul_first got %b want %b", hex_router, glyph(4'd2)); end
        if (hex_data_lo !== glyph(4'd2)) begin n_errors++; $display("FAIL simul_first_lo got %b want %b", hex_data_lo, glyph(4'd2)); end
        press_key();
        n_checks += 4;
        if (hex_router !== glyph(4'd7)) begin n_errors++; $display("FAIL simul_second got %b want %b", hex_router, glyph(4'd7)); end
        if (hex_data_hi !== glyph(4'd1)) begin n_errors++; $display("FAIL simul_hi got %b want %b", hex_data_hi, glyph(4'd1)); end
        if (hex_data_lo !== glyph(4'd1)) begin n_errors++; $display("FAIL simul_lo got %b want %b", hex_data_lo, glyph(4'd1)); end
        if (hex_count !== glyph(4'd1)) begin n_errors++; $display("FAIL simul_count_pop got %b want %b", hex_count, glyph(4'd1)); end
    endtask

    task automatic test_full();
        clear_all();
        rin[0] = 9'h1A1; rin[2] = 9'h1B3; rin[3] = 9'h1C4; rin[5] = 9'h1D6; rin[7] = 9'h1E8;
        ticks(7);
        n_checks += 4;
        if (hex_count !== glyph(4'd4)) begin n_errors++; $display("FAIL full_count got %b want %b", hex_count, glyph(4'd4)); end
        if (led_overrun !== 1'b0) begin n_errors++; $display("FAIL full_ovr got %b want 0", led_overrun); end
        if (hex_router !== glyph(4'd1)) begin n_errors++; $display("FAIL full_head got %b want %b", hex_router, glyph(4'd1)); end
        if (pkt_total !== m_total) begin n_errors++; $display("FAIL full_total got %0d want %0d", pkt_total, m_total); end
        press_key();
        n_checks += 2;
        if (hex_count !== glyph(4'd4)) begin n_errors++; $display("FAIL full_pop_count got %b want %b", hex_count, glyph(4'd4)); end
        if (hex_router !== glyph(4'd3)) begin n_errors++; $display("FAIL full_pop_head got %b want %b", hex_router, glyph(4'd3)); end
        ticks(2);
        n_checks += 1;
        if (pkt_total !== m_total) begin n_errors++; $display("FAIL full_pop_total got %0d want %0d", pkt_total, m_total); end
    endtask

    task automatic test_overrun();
        clear_all();
        rin[0] = 9'h100; rin[1] = 9'h111; rin[2] = 9'h122; rin[3] = 9'h133;
        ticks(6);
        rin[4] = 9'h133; tick();
        rin[4] = 9'h000; tick();
        rin[4] = 9'h144; tick();
        rin[4] = 9'h000; tick();
        n_checks += 1;
        if (led_overrun !== 1'b1) begin n_errors++; $display("FAIL ovr_flag got %b want 1", led_overrun); end
        for (int k = 0; k < 4; k++) press_key();
        n_checks += 3;
        if (hex_router !== glyph(4'd5)) begin n_errors++; $display("FAIL ovr_router got %b want %b", hex_router, glyph(4'd5)); end
        if (hex_data_hi !== glyph(4'd4)) begin n_errors++; $display("FAIL ovr_hi got %b want %b", hex_data_hi, glyph(4'd4)); end
        if (hex_data_lo !== glyph(4'd4)) begin n_errors++; $display("FAIL ovr_lo got %b want %b", hex_data_lo, glyph(4'd4)); end
    endtask

    task automatic test_empty_clear();
        logic [7:0] tot;
        clear_all();
        press_key(); press_key();
        n_checks += 3;
        if (hex_count !== glyph(4'd0)) begin n_errors++; $display("FAIL empty_count got %b want %b", hex_count, glyph(4'd0)); end
        if (hex_router !== DASH) begin n_errors++; $display("FAIL empty_router got %b want %b", hex_router, DASH); end
        if (hex_data_lo !== DASH) begin n_errors++; $display("FAIL empty_lo got %b want %b", hex_data_lo, DASH); end
        rin[0] = 9'h1F0; rin[1] = 9'h1E1; rin[2] = 9'h1D2;
        ticks(5);
        tot = m_total;
        n_checks += 1;
        if (hex_count !== glyph(4'd3)) begin n_errors++; $display("FAIL clear_pre_count got %b want %b", hex_count, glyph(4'd3)); end
        sw_clear = 1'b1; tick();
        sw_clear = 1'b0; tick();
        n_checks += 4;
        if (hex_count !== glyph(4'd0)) begin n_errors++; $display("FAIL clear_count got %b want %b", hex_count, glyph(4'd0)); end
        if (hex_data_hi !== DASH) begin n_errors++; $display("FAIL clear_hi got %b want %b", hex_data_hi, DASH); end
        if (led_overrun !== 1'b0) begin n_errors++; $display("FAIL clear_ovr got %b want 0", led_overrun); end
        if (pkt_total !== tot) begin n_errors++; $display("FAIL clear_total got %0d want %0d", pkt_total, tot); end
    endtask

    task automatic test_reset_mid();
        clear_all();
        rin[1] = 9'h1AA; rin[2] = 9'h1BB;
        ticks(5);
        rin[1] = 9'h000; rin[2] = 9'h000; rin[0] = 9'h15A;
        #1 rst_n = 1'b0;
        #1;
        n_checks += 4;
        if (hex_count !== glyph(4'd0)) begin n_errors++; $display("FAIL midrst_count got %b want %b", hex_count, glyph(4'd0)); end
        if (hex_router !== DASH) begin n_errors++; $display("FAIL midrst_router got %b want %b", hex_router, DASH); end
        if (pkt_total !== 8'd0) begin n_errors++; $display("FAIL midrst_total got %0d want 0", pkt_total); end
        if (led_overrun !== 1'b0) begin n_errors++; $display("FAIL midrst_ovr got %b want 0", led_overrun); end
        #1 rst_n = 1'b1;
        model_reset();
        ticks(3);
        n_checks += 5;
        if (hex_count !== glyph(4'd1)) begin n_errors++; $display("FAIL rerun_count got %b want %b", hex_count, glyph(4'd1)); end
        if (hex_router !== glyph(4'd1)) begin n_errors++; $display("FAIL rerun_router got %b want %b", hex_router, glyph(4'd1)); end
        if (hex_data_hi !== glyph(4'd5)) begin n_errors++; $display("FAIL rerun_hi got %b want %b", hex_data_hi, glyph(4'd5)); end
        if (hex_data_lo !== glyph(4'hA)) begin n_errors++; $display("FAIL rerun_lo got %b want %b", hex_data_lo, glyph(4'hA)); end
        if (pkt_total !== 8'd1) begin n_errors++; $display("FAIL rerun_total got %0d want 1", pkt_total); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 9; i++) begin
                rin[i] = {($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, 8'($urandom)};
            end
            key_next = ($urandom_range(0, 2) == 0);
            sw_clear = ($urandom_range(0, 39) == 0);
            tick();
            n_checks += 6;
            if (hex_router !== e_router) begin n_errors++; $display("FAIL rand_router cyc %0d got %b want %b", c, hex_router, e_router); end
            if (hex_data_hi !== e_hi) begin n_errors++; $display("FAIL rand_hi cyc %0d got %b want %b", c, hex_data_hi, e_hi); end
            if (hex_data_lo !== e_lo) begin n_errors++; $display("FAIL rand_lo cyc %0d got %b want %b", c, hex_data_lo, e_lo); end
            if (hex_count !== e_cnt) begin n_errors++; $display("FAIL rand_count cyc %0d got %b want %b", c, hex_count, e_cnt); end
            if (led_overrun !== m_ovr) begin n_errors++; $display("FAIL rand_ovr cyc %0d got %b want %b", c, led_overrun, m_ovr); end
            if (pkt_total !== m_total) begin n_errors++; $display("FAIL rand_total cyc %0d got %0d want %0d", c, pkt_total, m_total); end
        end
        sw_clear = 1'b0;
        key_next = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        sw_clear = 1'b0;
        key_next = 1'b0;
        for (int i = 0; i < 9; i++) rin[i] = 9'h000;
        model_reset();
        #12 rst_n = 1'b1;
        test_reset();
        test_single();
        test_simultaneous();
        test_full();
        test_overrun();
        test_empty_clear();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
